// File: rtl/key_beep_pkg.sv
// key_beep_pkg: shared definitions for the key-controlled buzzer.
//   state_t            - FSM state encoding (S_OFF, S_ON, S_CHIRP)
//   DEF_TONE_HALF0..3  - default tone half-periods in sys_clk cycles at 50 MHz
//   DEF_CHIRP_CYCLES   - default one-shot chirp length (100 ms at 50 MHz)
package key_beep_pkg;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ON    = 2'd1,
    S_CHIRP = 2'd2
  } state_t;

  localparam int DEF_TONE_HALF0   = 95555;  // ~261.6 Hz
  localparam int DEF_TONE_HALF1   = 85131;  // ~293.7 Hz
  localparam int DEF_TONE_HALF2   = 75843;  // ~329.6 Hz
  localparam int DEF_TONE_HALF3   = 71586;  // ~349.2 Hz
  localparam int DEF_CHIRP_CYCLES = 5000000;

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave generator with a programmable half-period.
//   sys_clk  - clock, rising edge
//   sys_rst  - synchronous active-high reset
//   enable   - run the generator; low holds counter and output at 0
//   restart  - clear counter and output this cycle (new tone / new entry)
//   half     - half-period in clock cycles (counter runs 0..half-1)
//   sq       - registered square wave, starts low, period 2*half
module tone_gen (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        enable,
  input  logic        restart,
  input  logic [16:0] half,
  output logic        sq
);

  logic [16:0] r_cnt;
  logic        r_sq;

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !enable || restart) begin
      r_cnt <= '0;
      r_sq  <= 1'b0;
    end else if (r_cnt == half - 17'd1) begin
      r_cnt <= '0;
      r_sq  <= ~r_sq;
    end else begin
      r_cnt <= r_cnt + 17'd1;
    end
  end

  assign sq = r_sq;

endmodule

// File: rtl/key_beep_ctrl.sv
// key_beep_ctrl: two-key passive-buzzer controller.
//   sys_clk    - clock, rising edge
//   sys_rst    - synchronous active-high reset
//   key_filter - debounced keys, active-low; [0] on/off, [1] tone/chirp
//   beep       - square-wave buzzer drive, idle 0
//   beep_en    - high while sounding (S_ON or S_CHIRP)
//   tone_sel   - currently selected tone 0..3
//   key_press  - one-cycle registered press pulses
// Key0 toggles continuous tone on/off; key1 cycles the tone while on, or
// fires a fixed-pitch chirp while off.
module key_beep_ctrl
  import key_beep_pkg::*;
#(
  parameter int TONE_HALF0   = DEF_TONE_HALF0,
  parameter int TONE_HALF1   = DEF_TONE_HALF1,
  parameter int TONE_HALF2   = DEF_TONE_HALF2,
  parameter int TONE_HALF3   = DEF_TONE_HALF3,
  parameter int CHIRP_CYCLES = DEF_CHIRP_CYCLES
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] key_filter,
  output logic       beep,
  output logic       beep_en,
  output logic [1:0] tone_sel,
  output logic [1:0] key_press
);

  logic [1:0]  r_key_prev;
  logic        r_armed;
  logic [1:0]  r_key_press;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_tone_sel;
  logic [1:0]  w_sel_nxt;
  logic        r_beep_en;
  logic [22:0] r_chirp_cnt;
  logic [16:0] w_half;
  logic        w_tone_en;
  logic        w_tone_restart;

  // r_armed masks the first cycle after reset: key_prev comes out of reset
  // as 11, so a key held through reset would otherwise look like a press.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_key_prev  <= 2'b11;
      r_armed     <= 1'b0;
      r_key_press <= 2'b00;
      r_state     <= S_OFF;
      r_tone_sel  <= 2'd0;
      r_beep_en   <= 1'b0;
      r_chirp_cnt <= '0;
    end else begin
      r_key_prev  <= key_filter;
      r_armed     <= 1'b1;
      r_key_press <= r_armed ? (r_key_prev & ~key_filter) : 2'b00;
      r_state     <= w_state_nxt;
      r_tone_sel  <= w_sel_nxt;
      r_beep_en   <= (w_state_nxt != S_OFF);
      if (w_state_nxt == S_CHIRP && r_state == S_CHIRP)
        r_chirp_cnt <= r_chirp_cnt + 23'd1;
      else
        r_chirp_cnt <= '0;
    end
  end

  // Key0 always wins over a simultaneous key1 event.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_tone_sel;
    case (r_state)
      S_OFF: begin
        if (r_key_press[0])      w_state_nxt = S_ON;
        else if (r_key_press[1]) w_state_nxt = S_CHIRP;
      end
      S_ON: begin
        if (r_key_press[0])      w_state_nxt = S_OFF;
        else if (r_key_press[1]) w_sel_nxt   = r_tone_sel + 2'd1;
      end
      S_CHIRP: begin
        if (r_key_press[0])                             w_state_nxt = S_ON;
        else if (r_chirp_cnt == 23'(CHIRP_CYCLES - 1)) w_state_nxt = S_OFF;
      end
      default: w_state_nxt = S_OFF;
    endcase
  end

  always_comb begin
    w_half = 17'(TONE_HALF3);
    if (r_state != S_CHIRP) begin
      case (r_tone_sel)
        2'd0:    w_half = 17'(TONE_HALF0);
        2'd1:    w_half = 17'(TONE_HALF1);
        2'd2:    w_half = 17'(TONE_HALF2);
        default: w_half = 17'(TONE_HALF3);
      endcase
    end
  end

  // Driven from next-state so the generator is cleared on the same edge the
  // state or tone changes; the new half-period takes over from that edge on.
  assign w_tone_en      = (w_state_nxt != S_OFF);
  assign w_tone_restart = (w_state_nxt != r_state) || (w_sel_nxt != r_tone_sel);

  tone_gen u_tone_gen (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .enable  (w_tone_en),
    .restart (w_tone_restart),
    .half    (w_half),
    .sq      (beep)
  );

  assign beep_en   = r_beep_en;
  assign tone_sel  = r_tone_sel;
  assign key_press = r_key_press;

endmodule

// File: tb/tb_key_beep_ctrl.sv
module tb_key_beep_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] key_filter;
  logic       beep, beep_en;
  logic [1:0] tone_sel, key_press;

  int ncmp = 0;
  int nerr = 0;

  key_beep_ctrl #(
    .TONE_HALF0(4), .TONE_HALF1(5), .TONE_HALF2(6), .TONE_HALF3(7),
    .CHIRP_CYCLES(20)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_filter (key_filter),
    .beep       (beep),
    .beep_en    (beep_en),
    .tone_sel   (tone_sel),
    .key_press  (key_press)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Press the keys in m (bit=1 pressed) for one cycle, then release. Returns
  // one step after the FSM edge, i.e. on the first sample of the new state.
  task automatic press(input logic [1:0] m);
    @(negedge sys_clk);
    key_filter = ~m;
    tick();
    chk("key_press_pulse", 32'(key_press), 32'(m));
    @(negedge sys_clk);
    key_filter = 2'b11;
    tick();
    chk("key_press_clear", 32'(key_press), 32'd0);
  endtask

  // Square wave starting low at sample 0: high in the second half of each period.
  task automatic pattern(input string tag, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      chk(tag, 32'(beep), 32'((k / h) % 2));
      tick();
    end
  endtask

  initial begin
    sys_rst    = 1'b1;
    key_filter = 2'b11;
    repeat (3) tick();
    chk("rst_beep",      32'(beep),      32'd0);
    chk("rst_beep_en",   32'(beep_en),   32'd0);
    chk("rst_tone_sel",  32'(tone_sel),  32'd0);
    chk("rst_key_press", 32'(key_press), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (3) tick();

    // key0 turns the tone on, tone 0 -> period 8
    press(2'b01);
    chk("on_beep_en", 32'(beep_en), 32'd1);
    pattern("tone0_wave", 4, 16);

    // key1 cycles tones 1,2,3 then wraps to 0, then 1
    press(2'b10);
    chk("sel1", 32'(tone_sel), 32'd1);
    pattern("tone1_wave", 5, 10);
    press(2'b10);
    chk("sel2", 32'(tone_sel), 32'd2);
    pattern("tone2_wave", 6, 12);
    press(2'b10);
    chk("sel3", 32'(tone_sel), 32'd3);
    pattern("tone3_wave", 7, 28);
    press(2'b10);
    chk("sel_wrap", 32'(tone_sel), 32'd0);
    pattern("tone0_again", 4, 16);
    press(2'b10);
    chk("sel1_again", 32'(tone_sel), 32'd1);

    // key0 turns it off
    press(2'b01);
    chk("off_beep_en", 32'(beep_en), 32'd0);
    chk("off_beep",    32'(beep),    32'd0);
    repeat (3) tick();
    chk("off_beep_hold", 32'(beep), 32'd0);

    // key1 from off: 20-cycle chirp at tone 3 pitch, tone_sel untouched
    press(2'b10);
    for (int k = 0; k < 20; k++) begin
      chk("chirp_en", 32'(beep_en), 32'd1);
      chk("chirp_wave", 32'(beep), 32'((k / 7) % 2));
      tick();
    end
    chk("chirp_end_en",   32'(beep_en),  32'd0);
    chk("chirp_end_beep", 32'(beep),     32'd0);
    chk("chirp_end_sel",  32'(tone_sel), 32'd1);

    // both keys at once from off: key0 wins -> on, tone 1
    press(2'b11);
    chk("both_en",  32'(beep_en),  32'd1);
    chk("both_sel", 32'(tone_sel), 32'd1);
    pattern("both_wave", 5, 10);
    press(2'b01);
    chk("both_off", 32'(beep_en), 32'd0);

    // chirp: key1 ignored, key0 aborts into continuous tone 1
    press(2'b10);
    chk("chirp2_en", 32'(beep_en), 32'd1);
    press(2'b10);
    chk("chirp_k1_en",  32'(beep_en),  32'd1);
    chk("chirp_k1_sel", 32'(tone_sel), 32'd1);
    press(2'b01);
    chk("abort_en", 32'(beep_en), 32'd1);
    pattern("abort_wave", 5, 10);
    press(2'b01);
    chk("abort_off", 32'(beep_en), 32'd0);

    // reset mid-chirp (beep high at cycle 10) with key0 held through release
    press(2'b10);
    repeat (10) tick();
    chk("pre_rst_beep", 32'(beep), 32'd1);
    @(negedge sys_clk);
    sys_rst    = 1'b1;
    key_filter = 2'b10;
    tick();
    chk("midrst_beep",      32'(beep),      32'd0);
    chk("midrst_beep_en",   32'(beep_en),   32'd0);
    chk("midrst_tone_sel",  32'(tone_sel),  32'd0);
    chk("midrst_key_press", 32'(key_press), 32'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("held_no_press", 32'(key_press), 32'd0);
      chk("held_off",      32'(beep_en),   32'd0);
    end
    @(negedge sys_clk);
    key_filter = 2'b11;
    repeat (2) tick();
    press(2'b01);
    chk("repress_on", 32'(beep_en), 32'd1);
    pattern("repress_wave", 4, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/key_beep_ctrl.md
KEY_BEEP_CTRL -- requirements
Module: key_beep_ctrl

Interface
REQ-001 SHALL have parameter TONE_HALF0, default 95555, meaning the tone 0 half-period in sys_clk cycles (about 261.6 Hz at 50 MHz).
REQ-002 SHALL have parameter TONE_HALF1, default 85131, meaning the tone 1 half-period (about 293.7 Hz).
REQ-003 SHALL have parameter TONE_HALF2, default 75843, meaning the tone 2 half-period (about 329.6 Hz).
REQ-004 SHALL have parameter TONE_HALF3, default 71586, meaning the tone 3 half-period (about 349.2 Hz).
REQ-005 SHALL have parameter CHIRP_CYCLES, default 5000000, meaning the one-shot chirp duration (100 ms).
REQ-006 SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port key_filter, input, 2 bits: debounced keys, active-low (0 = pressed); bit 0 is the on/off key and bit 1 is the tone key.
REQ-009 SHALL have port beep, output, 1 bit: square-wave drive for the passive buzzer; idle level is 0.
REQ-010 SHALL have port beep_en, output, 1 bit: high while the state is S_ON or S_CHIRP.
REQ-011 SHALL have port tone_sel, output, 2 bits: the currently selected tone.
REQ-012 SHALL have port key_press, output, 2 bits: one-cycle pulse per key press event.

Function
REQ-013 SHALL register key_filter into key_prev; a press event i SHALL be key_prev[i]=1 and key_filter[i]=0.
REQ-014 key_press[i] SHALL be registered, asserting for exactly one cycle on the edge after key_filter[i] falls; release SHALL generate no event.
REQ-015 FSM states SHALL be S_OFF, S_ON and S_CHIRP, with all outputs registered.
REQ-016 In S_OFF, a key0 event SHALL move the FSM to S_ON, and a key1 event alone SHALL move it to S_CHIRP.
REQ-017 In S_ON, a key0 event SHALL move the FSM to S_OFF, and a key1 event alone SHALL advance tone_sel 0->1->2->3->0 (wrap) while staying in S_ON.
REQ-018 In S_CHIRP, a chirp counter SHALL count CHIRP_CYCLES cycles, then return to S_OFF; a key0 event SHALL abort the chirp and go to S_ON; key1 events SHALL be ignored.
REQ-019 If key0 and key1 events occur in the same cycle, key0 SHALL take priority and key1 SHALL be discarded.
REQ-020 While in S_ON, the tone SHALL use TONE_HALF[tone_sel]; while in S_CHIRP, it SHALL use TONE_HALF3 regardless of tone_sel, and tone_sel SHALL be unchanged.
REQ-021 The tone counter SHALL be 17 bits, count 0..half-1, toggle beep and wrap to 0 at half-1, giving a period of 2*half cycles.
REQ-022 On entry to S_ON or S_CHIRP, and on any tone_sel change, the tone counter SHALL clear to 0 and beep SHALL restart low.
REQ-023 In S_OFF, beep SHALL be held at 0 and the tone counter at 0 within one cycle of entry.
REQ-024 The chirp counter SHALL be 23 bits, clear on S_CHIRP entry, and hold at 0 outside S_CHIRP.

Reset
REQ-025 When sys_rst=1 at a clock edge, the block SHALL set state=S_OFF, tone_sel=0, beep=0, beep_en=0, key_press=0, both counters=0, and key_prev=2'b11.
REQ-026 Reset asserted mid-tone or mid-chirp SHALL abort immediately, with no residual pulse on beep.
REQ-027 Holding a key pressed through reset release SHALL produce no event until the key is released and pressed again.

Structure
REQ-028 Shared package key_beep_pkg SHALL hold the state enumeration, the four default half-period constants, and the default CHIRP_CYCLES.
REQ-029 A sub-module tone_gen SHALL be instantiated, with inputs sys_clk, sys_rst, enable, restart and half[16:0], and output sq.

Verification
REQ-030 Benches SHALL override TONE_HALF0..3 = 4,5,6,7 and CHIRP_CYCLES = 20.
REQ-031 Reset, then key0 falls -> key_press=01 for 1 cycle, beep_en=1 on the next edge, and beep shows period 8 (4 high, 4 low).
REQ-032 In S_ON, three key1 presses -> tone_sel=3 and beep period 14; a fourth press -> tone_sel=0 and period 8, starting low.
REQ-033 In S_OFF, key1 press -> beep_en high for 20 cycles with beep period 14, then S_OFF, beep=0, and tone_sel unchanged.
REQ-034 Both keys fall in the same cycle from S_OFF -> state S_ON, tone_sel unchanged, and key_press=11 for one cycle.
REQ-035 In S_CHIRP at cycle 10, pulse sys_rst -> next edge all outputs are at reset values; with key0 held low through reset release, no key_press occurs.
